mult_div_unit: RTL and testbench

Multicycle signed multiply/divide unit for the MIPS multicycle datapath. It accepts one-cycle start pulses from the control FSM (`MULTcontrol` for funct 0x18, `DIVcontrol` for funct 0x1A), iterates over the operands latched from registers A and B, and writes the 64-bit result into the HI/LO registers. It returns `done`, plus `Div0` on a zero divisor, so the control FSM can leave its wait state or raise the divide-by-zero exception.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/restoring_divider.sv | 51 +++++
 rtl/mult_div_unit.sv | 144 ++++++++++++++
 tb/tb_mult_div_unit.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operand width, multiply/divide FSM
// states and the funct codes that the control FSM decodes.
package mips_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Handshake/bus between the control FSM + register file side (master)
// and the multiply/divide unit (slave).
//   MULTcontrol, DIVcontrol : one-cycle start pulses
//   A, B                    : operands from registers A and B
//   HI, LO                  : result registers
//   busy, done, Div0        : status back to the control FSM
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = mips_pkg::WIDTH
);
    logic             MULTcontrol;
    logic             DIVcontrol;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             Div0;

    modport master (
        output MULTcontrol, DIVcontrol, A, B,
        input  HI, LO, busy, done, Div0
    );

    modport slave (
        input  MULTcontrol, DIVcontrol, A, B,
        output HI, LO, busy, done, Div0
    );
endinterface

// File: rtl/restoring_divider.sv
// Unsigned restoring divider core: one quotient bit per enabled cycle.
//   clock, reset (async, active-low)
//   load     : latch dividend/divisor, clear partial remainder
//   step     : perform one restoring iteration
//   quotient : dividend shifts out the top while quotient bits enter below
//   remainder: partial remainder, final after WIDTH steps
module restoring_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Bring down the next dividend bit and try subtracting the divisor;
    // trial[WIDTH] set means the subtraction borrowed.
    always_comb begin
        shifted = {remainder, quotient[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quotient  <= '0;
            remainder <= '0;
            dvsr      <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dvsr      <= divisor;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit
// writing a 2*WIDTH-bit result into HI/LO.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : mult_div_unit_if.slave (starts, operands, HI/LO, busy/done/Div0)
module mult_div_unit #(
    parameter int unsigned WIDTH = mips_pkg::WIDTH
) (
    input logic            clock,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    import mips_pkg::*;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    md_state_t        state;
    logic [CW-1:0]    count;
    logic             op_div;
    logic             div0_flag;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] mcand;
    // Booth accumulator: hi carries one guard bit so that subtracting the
    // most negative multiplicand cannot overflow before the shift.
    logic [WIDTH:0]   booth_hi;
    logic [WIDTH-1:0] booth_lo;
    logic             booth_e;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, div0_q;

    logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
    logic             div_load_c;
    logic             div_step_c;

    assign a_mag = bus.A[WIDTH-1] ? (~bus.A) + WIDTH'(1) : bus.A;
    assign b_mag = bus.B[WIDTH-1] ? (~bus.B) + WIDTH'(1) : bus.B;

    assign div_load_c = (state == IDLE) && !bus.MULTcontrol && bus.DIVcontrol
                        && (bus.B != '0);
    assign div_step_c = (state == DIV);

    restoring_divider #(.WIDTH(WIDTH)) u_divider (
        .clock     (clock),
        .reset     (reset),
        .load      (div_load_c),
        .step      (div_step_c),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    // Booth recoding of the current multiplier bit pair
    always_comb begin
        booth_sum = booth_hi;
        case ({booth_lo[0], booth_e})
            2'b01:   booth_sum = booth_hi + {mcand[WIDTH-1], mcand};
            2'b10:   booth_sum = booth_hi - {mcand[WIDTH-1], mcand};
            default: booth_sum = booth_hi;
        endcase
    end

    // Control FSM, step counter, Booth accumulator, sign fix-up, HI/LO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            op_div    <= 1'b0;
            div0_flag <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            mcand     <= '0;
            booth_hi  <= '0;
            booth_lo  <= '0;
            booth_e   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (bus.MULTcontrol) begin
                        mcand    <= bus.A;
                        booth_hi <= '0;
                        booth_lo <= bus.B;
                        booth_e  <= 1'b0;
                        op_div   <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= MULT;
                    end else if (bus.DIVcontrol) begin
                        neg_q     <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                        neg_r     <= bus.A[WIDTH-1];
                        op_div    <= 1'b1;
                        div0_flag <= (bus.B == '0);
                        busy_q    <= 1'b1;
                        state     <= (bus.B == '0) ? FINISH : DIV;
                    end
                end
                MULT: begin
                    // Arithmetic right shift of {hi, lo, e} after the add
                    booth_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    booth_lo <= {booth_sum[0], booth_lo[WIDTH-1:1]};
                    booth_e  <= booth_lo[0];
                    count    <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FINISH;
                end
                DIV: begin
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FINISH;
                end
                FINISH: begin
                    if (div0_flag) begin
                        div0_q <= 1'b1;
                    end else if (op_div) begin
                        lo_q <= neg_q ? (~quo) + WIDTH'(1) : quo;
                        hi_q <= neg_r ? (~rem) + WIDTH'(1) : rem;
                    end else begin
                        hi_q <= booth_hi[WIDTH-1:0];
                        lo_q <= booth_lo;
                    end
                    div0_flag <= 1'b0;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Div0 = div0_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push their
// expected HI/LO/Div0; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_HI"}, bus.HI, e.hi);
                check({e.name, "_LO"}, bus.LO, e.lo);
                check({e.name, "_Div0"}, 32'(bus.Div0), 32'(e.div0));
            end
        end
    end

    // Issue one operation and check latency, busy length and done width.
    // inj >= 0 pulses DIVcontrol at that many cycles after the start edge.
    task automatic do_op(input string name, input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input int inj,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic ediv0);
        int lat;
        int busy_cycles;
        exp_t e;
        e.name = name; e.hi = ehi; e.lo = elo; e.div0 = ediv0;
        sb.push_back(e);
        @(negedge clock);
        bus.MULTcontrol = m;
        bus.DIVcontrol  = d;
        bus.A = a;
        bus.B = b;
        @(negedge clock);
        bus.MULTcontrol = 1'b0;
        bus.DIVcontrol  = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        lat = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (inj >= 0) bus.DIVcontrol = (lat == inj);
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clock);
            lat++;
        end
        bus.DIVcontrol = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_lat));
        check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clock);
        check({name, "_done_width"}, 32'(bus.done), 32'd0);
        check({name, "_div0_width"}, 32'(bus.Div0), 32'd0);
    endtask

    initial begin
        bus.MULTcontrol = 1'b0;
        bus.DIVcontrol  = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #12;
        check("reset_HI", bus.HI, 32'd0);
        check("reset_LO", bus.LO, 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_op("mult_7xm3", 1, 0, 32'd7, 32'hFFFF_FFFD, 33, -1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op("mult_min_sq", 1, 0, 32'h8000_0000, 32'h8000_0000, 33, -1, 32'h4000_0000, 32'h0, 0);
        do_op("div_7_m2", 0, 1, 32'd7, 32'hFFFF_FFFE, 33, -1, 32'h1, 32'hFFFF_FFFD, 0);
        do_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 33, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 33, -1, 32'h0, 32'h8000_0000, 0);
        do_op("div_100_7", 0, 1, 32'd100, 32'd7, 33, -1, 32'd2, 32'd14, 0);
        do_op("div_m100_m7", 0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, -1, 32'hFFFF_FFFE, 32'd14, 0);
        // 0x55555556 * 0x33333333 = 0x11111111_22222222, preloads HI/LO
        do_op("mult_preload", 1, 0, 32'h5555_5556, 32'h3333_3333, 33, -1, 32'h1111_1111, 32'h2222_2222, 0);
        do_op("div_by_zero", 0, 1, 32'd5, 32'd0, 1, -1, 32'h1111_1111, 32'h2222_2222, 1);
        do_op("both_starts", 1, 1, 32'd6, 32'd7, 33, -1, 32'h0, 32'd42, 0);
        do_op("mult_div_ignored", 1, 0, 32'hFFFF_FFFF, 32'h1234_5678, 33, 4, 32'hFFFF_FFFF, 32'hEDCB_A988, 0);

        // Reset asserted at step 10 of a divide aborts it with no result
        @(negedge clock);
        bus.DIVcontrol = 1'b1;
        bus.A = 32'd1000;
        bus.B = 32'd3;
        @(negedge clock);
        bus.DIVcontrol = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clock);
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_HI", bus.HI, 32'd0);
        check("abort_LO", bus.LO, 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_Div0", 32'(bus.Div0), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        do_op("mult_3x4", 1, 0, 32'd3, 32'd4, 33, -1, 32'h0, 32'd12, 0);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
